// File: rtl/fir_xifu_ex_simd.sv
// fir_xifu_ex_simd: EX stage of the FIR XIF unit.
// Runs the N-lane SIMD dot product with accumulate, and issues LW/SW requests with a post-incremented address.
//
// state | meaning
// IDLE  | waiting for an instruction from ID
// MUL   | lane-product sum being registered (only reachable when MUL_PIPE=1)
// MEM   | memory request presented, waiting for mem_ready_i
// WB    | result presented to WB, waiting for wb_ready_i
module fir_xifu_ex_simd #(
    parameter int ELEM_W   = 16,
    parameter int MUL_PIPE = 1,
    parameter int SATURATE = 0,
    parameter int STRIDE   = 4,
    parameter int ID_W     = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      in_instr_i,
    input  logic [31:0]     in_op_a_i,
    input  logic [31:0]     in_op_b_i,
    input  logic [31:0]     in_op_c_i,
    input  logic [31:0]     in_offset_i,
    input  logic [4:0]      in_rd_i,
    input  logic [ID_W-1:0] in_id_i,
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output logic [31:0]     mem_addr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [31:0]     mem_wdata_o,
    output logic [ID_W-1:0] mem_id_o,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [31:0]     wb_result_o,
    output logic [1:0]      wb_instr_o,
    output logic [4:0]      wb_rd_o,
    output logic [ID_W-1:0] wb_id_o,
    output logic            wb_err_o
);
    localparam int NLANES = 32 / ELEM_W;
    localparam int PW     = 2 * ELEM_W;
    localparam logic [1:0] I_DOTP = 2'd1, I_LW = 2'd2, I_SW = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_MEM, S_WB} state_t;
    state_t r_state, w_state_nxt;

    logic [1:0]      r_instr;
    logic [31:0]     r_op_a, r_op_b, r_op_c, r_addr;
    logic [4:0]      r_rd;
    logic [ID_W-1:0] r_id;
    logic            r_err;

    logic            w_ready, w_accept, w_misaligned, w_is_mem;
    logic [31:0]     w_addr_in, w_mul_a, w_mul_b, w_dotp_res;
    logic signed [PW-1:0] w_prod [NLANES];
    logic [33:0]     w_psum, w_dot, w_acc;

    // a WB handshake frees the stage in the same cycle, so the next instruction needs no bubble
    assign w_ready      = (r_state == S_IDLE || (r_state == S_WB && wb_ready_i)) && !clear_i;
    assign w_accept     = w_ready && in_valid_i;
    assign w_addr_in    = in_op_a_i + in_offset_i;
    assign w_misaligned = (w_addr_in[1:0] != 2'b00);
    assign w_is_mem     = (in_instr_i == I_LW) || (in_instr_i == I_SW);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      r_state <= S_IDLE;
        else if (clear_i) r_state <= S_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_MUL:   w_state_nxt = S_WB;
            S_MEM:   if (mem_ready_i) w_state_nxt = S_WB;
            S_WB:    if (wb_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = r_state;
        endcase
        if (w_accept) begin
            case (in_instr_i)
                I_DOTP:     w_state_nxt = (MUL_PIPE != 0) ? S_MUL : S_WB;
                I_LW, I_SW: w_state_nxt = w_misaligned ? S_WB : S_MEM;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || clear_i) begin
            r_instr <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_op_c  <= '0;
            r_addr  <= '0;
            r_rd    <= '0;
            r_id    <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_instr <= in_instr_i;
            r_op_a  <= in_op_a_i;
            r_op_b  <= in_op_b_i;
            r_op_c  <= in_op_c_i;
            r_addr  <= w_addr_in;
            r_rd    <= in_rd_i;
            r_id    <= in_id_i;
            r_err   <= w_is_mem && w_misaligned;
        end
    end

    // multipliers only toggle for DOTP
    assign w_mul_a = (r_instr == I_DOTP) ? r_op_a : '0;
    assign w_mul_b = (r_instr == I_DOTP) ? r_op_b : '0;

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        assign w_prod[g] = $signed(w_mul_a[g*ELEM_W +: ELEM_W]) * $signed(w_mul_b[g*ELEM_W +: ELEM_W]);
    end

    always_comb begin
        w_psum = '0;
        for (int i = 0; i < NLANES; i++) begin
            w_psum = w_psum + {{(34-PW){w_prod[i][PW-1]}}, w_prod[i]};
        end
    end

    if (MUL_PIPE != 0) begin : g_pipe
        logic [33:0] r_psum;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)               r_psum <= '0;
            else if (clear_i)          r_psum <= '0;
            else if (r_state == S_MUL) r_psum <= w_psum;
        end
        assign w_dot = r_psum;
    end else begin : g_nopipe
        assign w_dot = w_psum;
    end

    assign w_acc = w_dot + {{2{r_op_c[31]}}, r_op_c};

    always_comb begin
        w_dotp_res = w_acc[31:0];
        if (SATURATE != 0 && w_acc[33:31] != 3'b000 && w_acc[33:31] != 3'b111) begin
            w_dotp_res = w_acc[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    always_comb begin
        in_ready_o  = w_ready;
        mem_valid_o = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b1111;
        mem_wdata_o = '0;
        mem_id_o    = '0;
        wb_valid_o  = 1'b0;
        wb_result_o = '0;
        wb_instr_o  = '0;
        wb_rd_o     = '0;
        wb_id_o     = '0;
        wb_err_o    = 1'b0;
        case (r_state)
            S_MEM: begin
                mem_valid_o = 1'b1;
                mem_addr_o  = r_addr;
                mem_we_o    = (r_instr == I_SW);
                mem_wdata_o = r_op_b;
                mem_id_o    = r_id;
            end
            S_WB: begin
                wb_valid_o  = 1'b1;
                wb_result_o = (r_instr == I_DOTP) ? w_dotp_res : r_addr + 32'(STRIDE);
                wb_instr_o  = r_instr;
                wb_rd_o     = r_rd;
                wb_id_o     = r_id;
                wb_err_o    = r_err;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fir_xifu_ex_simd.sv
// Bench for fir_xifu_ex_simd: scoreboard on the default build, directed checks on an 8-bit saturating build.
module tb_fir_xifu_ex_simd;
    localparam logic [1:0] I_NOP = 2'd0, I_DOTP = 2'd1, I_LW = 2'd2, I_SW = 2'd3;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic [1:0]  in_instr = '0;
    logic [31:0] in_a = '0, in_b = '0, in_c = '0, in_off = '0;
    logic [4:0]  in_rd = '0;
    logic [3:0]  in_id = '0;
    logic        mem_ready = 1'b1, wb_ready = 1'b1;
    logic        in_ready, mem_valid, mem_we, wb_valid, wb_err;
    logic [31:0] mem_addr, mem_wdata, wb_result;
    logic [3:0]  mem_be, mem_id, wb_id;
    logic [1:0]  wb_instr;
    logic [4:0]  wb_rd;

    logic        v8 = 1'b0;
    logic [31:0] a8 = '0, b8 = '0, c8 = '0;
    logic        in_ready8, mem_valid8, mem_we8, wb_valid8, wb_err8;
    logic [31:0] mem_addr8, mem_wdata8, wb_result8;
    logic [3:0]  mem_be8, mem_id8, wb_id8;
    logic [1:0]  wb_instr8;
    logic [4:0]  wb_rd8;

    fir_xifu_ex_simd #(.ELEM_W(16), .MUL_PIPE(1), .SATURATE(0), .STRIDE(4), .ID_W(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr),
        .in_op_a_i(in_a), .in_op_b_i(in_b), .in_op_c_i(in_c), .in_offset_i(in_off),
        .in_rd_i(in_rd), .in_id_i(in_id),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_id_o(mem_id),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_result_o(wb_result), .wb_instr_o(wb_instr),
        .wb_rd_o(wb_rd), .wb_id_o(wb_id), .wb_err_o(wb_err)
    );

    fir_xifu_ex_simd #(.ELEM_W(8), .MUL_PIPE(0), .SATURATE(1), .STRIDE(4), .ID_W(4)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(v8), .in_ready_o(in_ready8), .in_instr_i(I_DOTP),
        .in_op_a_i(a8), .in_op_b_i(b8), .in_op_c_i(c8), .in_offset_i(32'd0),
        .in_rd_i(5'd1), .in_id_i(4'd1),
        .mem_valid_o(mem_valid8), .mem_ready_i(1'b1), .mem_addr_o(mem_addr8), .mem_we_o(mem_we8),
        .mem_be_o(mem_be8), .mem_wdata_o(mem_wdata8), .mem_id_o(mem_id8),
        .wb_valid_o(wb_valid8), .wb_ready_i(1'b1), .wb_result_o(wb_result8), .wb_instr_o(wb_instr8),
        .wb_rd_o(wb_rd8), .wb_id_o(wb_id8), .wb_err_o(wb_err8)
    );

    typedef struct {logic [31:0] res; logic [1:0] instr; logic [4:0] rd; logic [3:0] id; logic err;} wb_t;
    typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] id;} mem_t;
    wb_t  q_wb[$];
    mem_t q_mem[$];

    int n_chk = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dotp_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input int ew, input bit sat);
        longint acc, pa, pb;
        logic [31:0] sa, sb;
        acc = longint'($signed(c));
        for (int i = 0; i < 32 / ew; i++) begin
            sa = a >> (i * ew);
            sb = b >> (i * ew);
            if (ew == 8) begin
                pa = longint'($signed(sa[7:0]));
                pb = longint'($signed(sb[7:0]));
            end else begin
                pa = longint'($signed(sa[15:0]));
                pb = longint'($signed(sb[15:0]));
            end
            acc += pa * pb;
        end
        if (sat && acc > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (sat && acc < -64'sd2147483648) return 32'h8000_0000;
        return acc[31:0];
    endfunction

    task automatic push_exp();
        wb_t w;
        mem_t m;
        logic [31:0] addr;
        addr    = in_a + in_off;
        w.instr = in_instr;
        w.rd    = in_rd;
        w.id    = in_id;
        w.err   = 1'b0;
        w.res   = addr + 32'd4;
        if (in_instr == I_DOTP) begin
            w.res = dotp_model(in_a, in_b, in_c, 16, 1'b0);
            q_wb.push_back(w);
        end else if (in_instr != I_NOP) begin
            if (addr[1:0] != 2'b00) w.err = 1'b1;
            else begin
                m.addr  = addr;
                m.we    = (in_instr == I_SW);
                m.wdata = in_b;
                m.id    = in_id;
                q_mem.push_back(m);
            end
            q_wb.push_back(w);
        end
    endtask

    // returns just after the accepting edge
    task automatic issue(input logic [1:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] off, input logic [4:0] rd,
                         input logic [3:0] id);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_instr = ins; in_a = a; in_b = b; in_c = c; in_off = off; in_rd = rd; in_id = id;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("in_ready_wait", n < 50, 1'b1);
        @(posedge clk);
        push_exp();
    endtask

    task automatic release_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // scoreboard and hold-stability monitor, sampled mid-low-phase
    logic        wb_hold = 1'b0, mem_hold = 1'b0;
    logic [43:0] wb_prev;
    logic [36:0] mem_prev_a;
    logic [31:0] mem_prev_d;
    initial begin
        wb_t  ew;
        mem_t em;
        forever begin
            @(negedge clk);
            #2;
            if (wb_hold) begin
                check_eq("wb_held_valid", wb_valid, 1'b1);
                check_eq("wb_held_data", {wb_result, wb_rd, wb_id, wb_err, wb_instr}, wb_prev);
            end
            if (mem_hold) begin
                check_eq("mem_held_valid", mem_valid, 1'b1);
                check_eq("mem_held_req", {mem_addr, mem_id, mem_we}, mem_prev_a);
                check_eq("mem_held_wdata", mem_wdata, mem_prev_d);
            end
            if (wb_valid && wb_ready && !clear) begin
                if (q_wb.size() == 0) check_eq("wb_unexpected", 1'b1, 1'b0);
                else begin
                    ew = q_wb.pop_front();
                    check_eq("wb_result", wb_result, ew.res);
                    check_eq("wb_tag", {wb_instr, wb_rd, wb_id, wb_err}, {ew.instr, ew.rd, ew.id, ew.err});
                end
            end
            if (mem_valid && mem_ready && !clear) begin
                if (q_mem.size() == 0) check_eq("mem_unexpected", 1'b1, 1'b0);
                else begin
                    em = q_mem.pop_front();
                    check_eq("mem_req", {mem_addr, mem_id, mem_we, mem_be}, {em.addr, em.id, em.we, 4'hF});
                    check_eq("mem_wdata", mem_wdata, em.wdata);
                end
            end
            wb_hold    = wb_valid && !wb_ready && !clear && rst_n;
            mem_hold   = mem_valid && !mem_ready && !clear && rst_n;
            wb_prev    = {wb_result, wb_rd, wb_id, wb_err, wb_instr};
            mem_prev_a = {mem_addr, mem_id, mem_we};
            mem_prev_d = mem_wdata;
        end
    end

    task automatic dotp8_one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        @(negedge clk);
        v8 = 1'b1; a8 = a; b8 = b; c8 = c;
        #1 check_eq("d8_ready", in_ready8, 1'b1);
        @(negedge clk);
        v8 = 1'b0;
        #1 check_eq("d8_valid", wb_valid8, 1'b1);
        check_eq("d8_result", wb_result8, dotp_model(a, b, c, 8, 1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    logic [31:0] r_a, r_b, r_c;
    initial begin
        repeat (2) @(negedge clk);
        #1 check_eq("rst_outputs", {wb_valid, mem_valid, wb_result, mem_addr, mem_wdata, wb_rd, wb_err, mem_we}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("rst_in_ready", in_ready, 1'b1);

        // dotp latency with MUL_PIPE=1
        issue(I_DOTP, 32'h0003_FFFE, 32'h0004_0005, 32'd10, 32'd0, 5'd3, 4'd1);
        release_in();
        #1 check_eq("dotp_lat1", wb_valid, 1'b0);
        @(negedge clk);
        #1 check_eq("dotp_lat2", wb_valid, 1'b1);
        check_eq("dotp_t1", wb_result, 32'd12);

        // store under memory back-pressure
        mem_ready = 1'b0;
        issue(I_SW, 32'h0000_1000, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFC, 5'd7, 4'd2);
        release_in();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1 check_eq("sw_mem_valid", mem_valid, 1'b1);
            check_eq("sw_req", {mem_addr, mem_we, mem_wdata}, {32'h0000_0FFC, 1'b1, 32'hDEAD_BEEF});
            @(negedge clk);
        end
        #1 check_eq("sw_mem_done", mem_valid, 1'b0);
        check_eq("sw_wb", wb_result, 32'h0000_1000);

        // misaligned load skips memory
        issue(I_LW, 32'h0000_1002, 32'd0, 32'd0, 32'd0, 5'd4, 4'd3);
        release_in();
        #1 check_eq("lw_mis", {wb_valid, wb_err, mem_valid, wb_result}, {1'b1, 1'b1, 1'b0, 32'h0000_1006});

        // address wrap, back-to-back mixed traffic, a dropped NOP
        issue(I_LW, 32'hFFFF_FFFC, 32'h55, 32'd0, 32'd4, 5'd5, 4'd4);
        issue(I_NOP, 32'd1, 32'd2, 32'd3, 32'd0, 5'd6, 4'd5);
        issue(I_DOTP, 32'h8000_8000, 32'h8000_8000, 32'h7FFF_FFFF, 32'd0, 5'd8, 4'd6);
        issue(I_DOTP, 32'h7FFF_0001, 32'hFFFF_0002, 32'hFFFF_FFF0, 32'd0, 5'd9, 4'd7);
        for (int i = 0; i < 10; i++) begin
            r_a = $urandom; r_b = $urandom; r_c = $urandom;
            issue(2'(i % 4), (i % 4 == 1) ? r_a : {r_a[31:12], 12'h100}, r_b, r_c,
                  32'($urandom_range(0, 5)), 5'(i), 4'(i));
        end
        release_in();
        repeat (4) @(negedge clk);

        // WB back-pressure holds result and blocks the next instruction
        wb_ready = 1'b0;
        issue(I_DOTP, 32'h1234_5678, 32'h9ABC_DEF0, 32'd77, 32'd0, 5'd10, 4'd8);
        @(negedge clk);
        in_instr = I_DOTP; in_a = 32'h0002_0003; in_b = 32'h0004_0005; in_c = 32'd1; in_rd = 5'd11; in_id = 4'd9;
        for (int i = 0; i < 5; i++) begin
            #1 check_eq("bp_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1 check_eq("bp_release_ready", in_ready, 1'b1);
        @(posedge clk);
        push_exp();
        release_in();
        repeat (3) @(negedge clk);

        // clear together with valid does not accept
        @(negedge clk);
        in_valid = 1'b1; in_instr = I_DOTP; clear = 1'b1;
        #1 check_eq("clr_no_ready", in_ready, 1'b0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        #1 check_eq("clr_no_accept", wb_valid, 1'b0);
        @(negedge clk);
        #1 check_eq("clr_no_accept2", wb_valid, 1'b0);

        // clear in MEM
        mem_ready = 1'b0;
        issue(I_SW, 32'h0000_2000, 32'h1111_2222, 32'd0, 32'd8, 5'd12, 4'd10);
        release_in();
        #1 check_eq("clr_mem_pre", mem_valid, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1 check_eq("clr_mem", {mem_valid, in_ready}, 2'b01);
        q_mem.delete(q_mem.size() - 1);
        q_wb.delete(q_wb.size() - 1);
        mem_ready = 1'b1;

        // clear in WB
        wb_ready = 1'b0;
        issue(I_LW, 32'h0000_3001, 32'd0, 32'd0, 32'd0, 5'd13, 4'd11);
        release_in();
        #1 check_eq("clr_wb_pre", wb_valid, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1 check_eq("clr_wb", {wb_valid, in_ready}, 2'b01);
        q_wb.delete(q_wb.size() - 1);
        wb_ready = 1'b1;

        // async reset mid-MUL
        issue(I_DOTP, 32'h0001_0001, 32'h0001_0001, 32'd5, 32'd0, 5'd14, 4'd12);
        release_in();
        #1 rst_n = 1'b0;
        #1 check_eq("rst_mid_mul", {wb_valid, mem_valid, wb_result, wb_rd, wb_id, wb_err, mem_addr}, '0);
        q_wb.delete(q_wb.size() - 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check_eq("rst_no_result", wb_valid, 1'b0);

        // 8-bit lanes, saturating, no multiplier pipe
        dotp8_one(32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7FFF_FF00);
        check_eq("d8_sat_pos", wb_result8, 32'h7FFF_FFFF);
        dotp8_one(32'h8080_8080, 32'h7F7F_7F7F, 32'h8000_0000);
        check_eq("d8_sat_neg", wb_result8, 32'h8000_0000);
        dotp8_one(32'h01FF_0203, 32'h0405_0607, 32'd5);
        check_eq("d8_plain", wb_result8, 32'd37);
        @(negedge clk);
        v8 = 1'b1; a8 = 32'h0102_0304; b8 = 32'h0506_0708; c8 = 32'd0;
        @(negedge clk);
        a8 = 32'hFFFE_FDFC; b8 = 32'h0102_0304; c8 = 32'd100;
        #1 check_eq("d8_b2b_first", {wb_valid8, in_ready8, wb_result8},
                    {1'b1, 1'b1, dotp_model(32'h0102_0304, 32'h0506_0708, 32'd0, 8, 1'b1)});
        @(negedge clk);
        v8 = 1'b0;
        #1 check_eq("d8_b2b_second", {wb_valid8, wb_result8},
                    {1'b1, dotp_model(32'hFFFE_FDFC, 32'h0102_0304, 32'd100, 8, 1'b1)});
        @(negedge clk);
        #1 check_eq("d8_b2b_done", wb_valid8, 1'b0);

        repeat (3) @(negedge clk);
        check_eq("wb_q_empty", q_wb.size(), 0);
        check_eq("mem_q_empty", q_mem.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
